calc_display_mux: RTL and testbench
===================================

// Module: calc_display_mux
// PURPOSE
// - Downstream stage of the calculator core: consumes its status/data/pos digit stream.
// - Holds an 8-digit frame buffer; time-multiplexes it onto 8 common-anode 7-segment displays.
// - Adds error-message override, busy indicator and leading-zero blanking.
// PARAMETERS
// - REFRESH_DIV  100000  clock cycles each digit stays lit (>=2)
// - NUM_DIGITS   8       display count; pos values >= NUM_DIGITS are ignored
// - POS_SKEW     1       write address = pos - POS_SKEW (mod 16); data lags pos by one clock
// PORTS
// - clock   in   1  system clock
// - reset   in   1  asynchronous, active-high
// - status  in   2  00 error, 01 busy, 10 ready, 11 printing
// - data    in   4  BCD digit being printed
// - pos     in   4  digit position from the core (0 = rightmost)
// - an      out  8  anode enables, active-low, one-hot-cold
// - seg     out  8  {dp,g,f,e,d,c,b,a}, active-low
// BEHAVIOUR
// - Reset: an=8'hFF, seg=8'hFF, all buffer slots blank/invalid, scan index 0, divider 0.
// - Frame start: cycle where status==11 and previous status!=11 clears all slots to blank.
// - Write: each cycle with status==11, addr=pos-POS_SKEW; if addr<NUM_DIGITS, slot[addr]<=data and becomes valid.
// - Clear and write in the same cycle: the write wins for its slot; all other slots clear.
// - Writes are never accepted outside status==11; the buffer holds its contents across other states.
// - Scan: divider counts 0..REFRESH_DIV-1; at terminal count, scan index +1 mod NUM_DIGITS, divider wraps to 0.
// - an/seg are registered and update one clock after the scan index changes; no two anodes are ever low together.
// - Digit 0 is always shown. Digit k>0 is blank if no valid nonzero slot exists at index >= k (leading-zero blanking).
// - Decode: 0-9 standard; 10-15 -> '-' (seg g only); blank -> all segments off.
// - status==00 overrides the buffer. Digits 4..0 show "Error"; digits 7..5 are blank. The buffer is not modified.
// - status==01: dp of digit 0 is lit (busy indicator). dp is off in all other states.
// - Mid-operation reset clears everything immediately. Outputs read all-off until the first registered update after reset release.
// - The frame buffer and the scan logic run independently: a write takes effect at the next scan visit of that digit.
// STRUCTURE
// - calc_pkg: status codes (ST_ERR/ST_BUSY/ST_READY/ST_PRINT), SEG_BLANK, SEG_MINUS, SEG_E/r/o patterns, NUM_DIGITS default.
// - Sub-module seg7_decoder: combinational {blank,val[3:0]} -> seg[6:0]; a pure function, instanced once on the scan path.
// - Top level: frame buffer and valid bits, frame-start edge detect, divider, scan index, blanking logic, output registers.
// TESTING (sim with REFRESH_DIV=4)
// - Reset asserted mid-scan -> an=FF, seg=FF the same cycle; after release, digit 0 is driven within 5 cycles.
// - status=11 with pos 1,2,3 and data 7,4,2 (POS_SKEW=1) -> slots 0..2 = 7,4,2; scan shows "247" with digits 3..7 blank.
// - Enter status 11 again, write only slot 0 = 5 -> previous digits cleared; only digit 0 shows '5'.
// - Slot 0 = 0 and no other digits written -> digit 0 shows '0' (seg=8'hC0); all other anodes show blank (seg=8'hFF).
// - status=00 -> digits 4..0 read E,r,r,o,r; return to 10 -> the buffered number reappears unchanged.
// - status=01 -> seg[7]=0 only while an[0]=0; a pos=9 write is ignored with no buffer change.

Source files
------------

// File: rtl/calc_display_mux_pkg.sv
// Shared status codes, segment patterns and defaults for the calculator display slice.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package calc_pkg;

   typedef enum logic [1:0] {
      ST_ERR   = 2'b00,
      ST_BUSY  = 2'b01,
      ST_READY = 2'b10,
      ST_PRINT = 2'b11
   } status_t;

   localparam int unsigned DEF_NUM_DIGITS = 8;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_MINUS = 7'h3F;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_R     = 7'h2F;
   localparam logic [6:0] SEG_O     = 7'h23;

   // "Error" spelled across digits 4..0; everything else dark.
   function automatic logic [6:0] err_seg(input int unsigned k);
      case (k)
         4:       return SEG_E;
         3, 2, 0: return SEG_R;
         1:       return SEG_O;
         default: return SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/calc_display_mux_if.sv
// Digit stream from the calculator core plus the multiplexed display drive.
interface calc_display_mux_if #(
   parameter int unsigned NUM_DIGITS = 8
);
   logic [1:0]            status;
   logic [3:0]            data;
   logic [3:0]            pos;
   logic [NUM_DIGITS-1:0] an;
   logic [7:0]            seg;

   modport master (output status, data, pos, input an, seg);
   modport slave  (input status, data, pos, output an, seg);
endinterface

// File: rtl/calc_display_mux_seg7_decoder.sv
// Combinational BCD to 7-segment decoder, active-low {g,f,e,d,c,b,a}.
module seg7_decoder
   import calc_pkg::*;
(
   input  logic       blank,
   input  logic [3:0] val,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (!blank) begin
         case (val)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_MINUS;
         endcase
      end
   end

endmodule

// File: rtl/calc_display_mux.sv
// Frame buffer fed by the core's digit stream, scanned onto common-anode 7-segment displays
// with error override, busy dot and leading-zero blanking.
module calc_display_mux
   import calc_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned NUM_DIGITS  = DEF_NUM_DIGITS,
   parameter int unsigned POS_SKEW    = 1
) (
   input  logic               clock,
   input  logic               reset,
   calc_display_mux_if.slave  bus
);

   localparam int unsigned DIV_W = $clog2(REFRESH_DIV);
   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   logic [3:0]            slot [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] valid;
   logic [NUM_DIGITS-1:0] lead;
   logic [1:0]            prev_status;
   logic [DIV_W-1:0]      div;
   logic [IDX_W-1:0]      idx;

   logic [3:0]            addr;
   logic [IDX_W-1:0]      wr_idx;
   logic                  frame_start;
   logic                  wr_en;
   logic                  cur_blank;
   logic [6:0]            dec_seg;
   logic [6:0]            digit_seg;
   logic                  dp_on;
   logic [NUM_DIGITS-1:0] an_n;
   logic [7:0]            seg_n;

   assign addr        = bus.pos - 4'(POS_SKEW);
   assign wr_idx      = addr[IDX_W-1:0];
   assign frame_start = (bus.status == ST_PRINT) && (prev_status != ST_PRINT);
   assign wr_en       = (bus.status == ST_PRINT) && (32'(addr) < NUM_DIGITS);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prev_status <= ST_ERR;
         valid       <= '0;
         for (int unsigned i = 0; i < NUM_DIGITS; i++) slot[i] <= '0;
      end else begin
         prev_status <= bus.status;
         if (frame_start) begin
            valid <= '0;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) slot[i] <= '0;
         end
         // Placed after the clear so a same-cycle write keeps its slot.
         if (wr_en) begin
            slot[wr_idx]  <= bus.data;
            valid[wr_idx] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         div <= '0;
         idx <= '0;
      end else if (div == DIV_W'(REFRESH_DIV - 1)) begin
         div <= '0;
         idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
         div <= div + 1'b1;
      end
   end

   // lead[k]: some valid nonzero digit sits at index k or above.
   always_comb begin : lead_scan
      logic nz;
      nz   = 1'b0;
      lead = '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         nz = nz | (valid[NUM_DIGITS-1-i] && (slot[NUM_DIGITS-1-i] != 4'd0));
         lead[NUM_DIGITS-1-i] = nz;
      end
   end

   assign cur_blank = (idx != '0) && (!valid[idx] || !lead[idx]);

   seg7_decoder u_dec (
      .blank (cur_blank),
      .val   (slot[idx]),
      .seg   (dec_seg)
   );

   always_comb begin
      digit_seg = (bus.status == ST_ERR) ? err_seg(32'(idx)) : dec_seg;
      dp_on     = (bus.status == ST_BUSY) && (idx == '0);
      an_n      = ~(NUM_DIGITS'(1) << idx);
      seg_n     = {~dp_on, digit_seg};
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bus.an  <= '1;
         bus.seg <= '1;
      end else begin
         bus.an  <= an_n;
         bus.seg <= seg_n;
      end
   end

endmodule

// File: tb/tb_calc_display_mux.sv
// Scoreboard bench for calc_display_mux: a digit-array model predicts every registered an/seg
// value, a monitor compares them on the falling edge.
module tb_calc_display_mux;
   import calc_pkg::*;

   localparam int unsigned RDIV = 4;
   localparam int ND = 8;

   typedef struct {
      logic [7:0] an;
      logic [7:0] seg;
   } exp_t;

   logic clock = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t q[$];

   // Model state: displayed number as an array of digits, -1 = not written this frame.
   int         m_digit [ND];
   int         m_cycle;
   logic [1:0] m_prev;

   calc_display_mux_if #(.NUM_DIGITS(ND)) bus ();

   calc_display_mux #(
      .REFRESH_DIV (RDIV),
      .NUM_DIGITS  (ND),
      .POS_SKEW    (1)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   function automatic logic [7:0] pat(input int v);
      case (v)
         -1:      return 8'hFF;
         0:       return 8'hC0;
         1:       return 8'hF9;
         2:       return 8'hA4;
         3:       return 8'hB0;
         4:       return 8'h99;
         5:       return 8'h92;
         6:       return 8'h82;
         7:       return 8'hF8;
         8:       return 8'h80;
         9:       return 8'h90;
         default: return 8'hBF;
      endcase
   endfunction

   function automatic exp_t expect_out(input logic [1:0] st, input int k);
      exp_t e;
      int   msd;
      int   v;
      e.an = ~(8'b1 << k);
      msd  = -1;
      for (int j = 0; j < ND; j++) if (m_digit[j] > 0) msd = j;
      if (st == 2'b00) begin
         if (k == 4)                          e.seg = 8'h86;
         else if (k == 1)                     e.seg = 8'hA3;
         else if (k == 0 || k == 2 || k == 3) e.seg = 8'hAF;
         else                                 e.seg = 8'hFF;
      end else begin
         if (k == 0)                           v = (m_digit[0] < 0) ? 0 : m_digit[0];
         else if (m_digit[k] >= 0 && k <= msd) v = m_digit[k];
         else                                  v = -1;
         e.seg = pat(v);
         if (st == 2'b01 && k == 0) e.seg[7] = 1'b0;
      end
      return e;
   endfunction

   initial begin : model
      int addr;
      forever begin
         @(posedge clock or posedge reset);
         if (reset) begin
            m_cycle = 0;
            m_prev  = 2'b00;
            for (int j = 0; j < ND; j++) m_digit[j] = -1;
            q.delete();
         end else begin
            q.push_back(expect_out(bus.status, (m_cycle / RDIV) % ND));
            m_cycle++;
            if (bus.status == 2'b11) begin
               if (m_prev != 2'b11) for (int j = 0; j < ND; j++) m_digit[j] = -1;
               addr = (int'(bus.pos) + 15) % 16;
               if (addr < ND) m_digit[addr] = int'(bus.data);
            end
            m_prev = bus.status;
         end
      end
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clock);
         if (q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            if (bus.an !== e.an || bus.seg !== e.seg) begin
               n_bad++;
               $display("FAIL scan: an=%h seg=%h, expected an=%h seg=%h (t=%0t)",
                        bus.an, bus.seg, e.an, e.seg, $time);
            end
         end
      end
   end

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
      end
   endtask

   task automatic step(input logic [1:0] st, input logic [3:0] p, input logic [3:0] d);
      bus.status = st;
      bus.pos    = p;
      bus.data   = d;
      @(negedge clock);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic mid_reset(input string name);
      logic found;
      #2 reset = 1'b1;
      #1 check({name, "_immediate"}, {bus.an, bus.seg}, 16'hFFFF);
      @(negedge clock);
      check({name, "_held"}, {bus.an, bus.seg}, 16'hFFFF);
      reset = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 5 && !found; i++) begin
         @(negedge clock);
         if (bus.an == 8'hFE) found = 1'b1;
      end
      check({name, "_digit0_within_5"}, {15'd0, found}, 16'd1);
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not end, expected completion");
      $fatal(1);
   end

   initial begin : stimulus
      logic [1:0] st;
      int         len;
      reset      = 1'b1;
      bus.status = ST_READY;
      bus.pos    = '0;
      bus.data   = '0;
      idle(3);
      check("reset_outputs", {bus.an, bus.seg}, 16'hFFFF);
      reset = 1'b0;
      idle(13);
      mid_reset("reset_mid_scan");

      step(ST_READY, 4'd0, 4'd0);
      step(ST_PRINT, 4'd1, 4'd7);
      step(ST_PRINT, 4'd2, 4'd4);
      step(ST_PRINT, 4'd3, 4'd2);
      step(ST_READY, 4'd0, 4'd0);
      idle(40);

      step(ST_PRINT, 4'd1, 4'd5);
      step(ST_READY, 4'd0, 4'd0);
      idle(40);

      step(ST_PRINT, 4'd1, 4'd0);
      step(ST_READY, 4'd0, 4'd0);
      idle(40);

      step(ST_PRINT, 4'd1, 4'd3);
      step(ST_PRINT, 4'd3, 4'd12);
      step(ST_ERR, 4'd2, 4'd9);
      idle(40);
      step(ST_READY, 4'd0, 4'd0);
      idle(40);

      step(ST_BUSY, 4'd0, 4'd0);
      idle(40);
      step(ST_PRINT, 4'd1, 4'd3);
      step(ST_PRINT, 4'd9, 4'd6);
      step(ST_PRINT, 4'd0, 4'd8);
      step(ST_BUSY, 4'd9, 4'd6);
      idle(40);

      for (int g = 0; g < 70; g++) begin
         st  = 2'($urandom_range(0, 3));
         len = $urandom_range(1, 12);
         repeat (len) step(st, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         if (g == 35) mid_reset("reset_random");
         if (g % 10 == 9) begin
            step(ST_READY, 4'd0, 4'd0);
            idle(32);
         end
      end
      step(ST_READY, 4'd0, 4'd0);
      idle(40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
